// File: rtl/frame_tick_scheduler.sv
// frame_tick_scheduler: per-frame sequencer for the entity update datapath.
// Latches the controller word on an accepted frame tick, then strobes each
// enabled slot in ascending order and waits for that slot's done handshake
// before moving to the next slot.
//
// Optional feature macro: SCHED_WATCHDOG_EN (per-slot WAIT watchdog).
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   frame_tick     single-cycle frame pulse
//   input_data     raw controller word
//   slot_enable    per-slot enable, sampled when the slot is scanned
//   slot_done      per-slot completion handshake
//   clear_overrun  clears the sticky overrun flag
//   slot_start     one-hot, one-cycle start strobe
//   active_slot    index of the slot being scanned or awaited
//   input_latched  controller snapshot for the current frame
//   frame_busy     high from tick acceptance until frame_done
//   frame_done     one-cycle end-of-sequence pulse
//   overrun        sticky: tick arrived while busy
//   timeout_flags  sticky per-slot watchdog flags
module frame_tick_scheduler #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned INPUT_W   = 10,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [INPUT_W-1:0]   input_data,
    input  logic [NUM_SLOTS-1:0] slot_enable,
    input  logic [NUM_SLOTS-1:0] slot_done,
    input  logic                 clear_overrun,
    output logic [NUM_SLOTS-1:0] slot_start,
    output logic [2:0]           active_slot,
    output logic [INPUT_W-1:0]   input_latched,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 overrun,
    output logic [NUM_SLOTS-1:0] timeout_flags
);

    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [NUM_SLOTS-1:0] r_slot_start, w_slot_start_nxt;
    logic [INPUT_W-1:0]   r_input_latched, w_input_latched_nxt;
    logic                 r_frame_busy, w_frame_busy_nxt;
    logic                 r_frame_done, w_frame_done_nxt;
    logic                 r_overrun, w_overrun_nxt;

    logic                 w_en_cur;
    logic                 w_done_cur;
    logic [NUM_SLOTS-1:0] w_onehot;

`ifdef SCHED_WATCHDOG_EN
    logic [7:0]           r_wd_cnt, w_wd_cnt_nxt;
    logic [NUM_SLOTS-1:0] r_timeout_flags, w_timeout_flags_nxt;
`else
    logic [7:0]           w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT);
`endif

    // Select the enable/done bits of the current slot; idx==NUM_SLOTS selects nothing.
    always_comb begin
        w_en_cur   = 1'b0;
        w_done_cur = 1'b0;
        w_onehot   = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_en_cur    = slot_enable[i];
                w_done_cur  = slot_done[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_slot_start    <= '0;
            r_input_latched <= '0;
            r_frame_busy    <= 1'b0;
            r_frame_done    <= 1'b0;
            r_overrun       <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
            r_wd_cnt        <= '0;
            r_timeout_flags <= '0;
`endif
        end else begin
            r_state         <= w_state_nxt;
            r_idx           <= w_idx_nxt;
            r_slot_start    <= w_slot_start_nxt;
            r_input_latched <= w_input_latched_nxt;
            r_frame_busy    <= w_frame_busy_nxt;
            r_frame_done    <= w_frame_done_nxt;
            r_overrun       <= w_overrun_nxt;
`ifdef SCHED_WATCHDOG_EN
            r_wd_cnt        <= w_wd_cnt_nxt;
            r_timeout_flags <= w_timeout_flags_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt         = r_state;
        w_idx_nxt           = r_idx;
        w_slot_start_nxt    = '0;
        w_input_latched_nxt = r_input_latched;
        w_frame_busy_nxt    = r_frame_busy;
        w_frame_done_nxt    = 1'b0;
`ifdef SCHED_WATCHDOG_EN
        w_wd_cnt_nxt        = r_wd_cnt;
        w_timeout_flags_nxt = r_timeout_flags;
`endif

        // A tick while busy is dropped; a coincident clear loses to the set.
        if (frame_tick && r_frame_busy) begin
            w_overrun_nxt = 1'b1;
        end else if (clear_overrun) begin
            w_overrun_nxt = 1'b0;
        end else begin
            w_overrun_nxt = r_overrun;
        end

        case (r_state)
            S_IDLE: begin
                if (frame_tick) begin
                    w_input_latched_nxt = input_data;
                    w_idx_nxt           = '0;
                    w_frame_busy_nxt    = 1'b1;
                    w_state_nxt         = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_idx == IDX_W'(NUM_SLOTS)) begin
                    w_frame_done_nxt = 1'b1;
                    w_frame_busy_nxt = 1'b0;
                    w_state_nxt      = S_IDLE;
                end else if (!w_en_cur) begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end else begin
                    w_slot_start_nxt = w_onehot;
`ifdef SCHED_WATCHDOG_EN
                    w_wd_cnt_nxt     = '0;
`endif
                    w_state_nxt      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_done_cur) begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_state_nxt = S_SCAN;
`ifdef SCHED_WATCHDOG_EN
                end else if (r_wd_cnt == 8'(TIMEOUT - 1)) begin
                    // TIMEOUT-th WAIT edge without done: flag the slot and skip it.
                    w_timeout_flags_nxt = r_timeout_flags | w_onehot;
                    w_idx_nxt           = r_idx + IDX_W'(1);
                    w_state_nxt         = S_SCAN;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + 8'd1;
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign slot_start    = r_slot_start;
    assign active_slot   = r_idx[2:0];
    assign input_latched = r_input_latched;
    assign frame_busy    = r_frame_busy;
    assign frame_done    = r_frame_done;
    assign overrun       = r_overrun;
`ifdef SCHED_WATCHDOG_EN
    assign timeout_flags = r_timeout_flags;
`else
    assign timeout_flags = '0;
`endif

endmodule

// File: tb/tb_frame_tick_scheduler.sv
// Directed testbench for frame_tick_scheduler (NUM_SLOTS=4, INPUT_W=10, TIMEOUT=15).
module tb_frame_tick_scheduler;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic [9:0] input_data;
    logic [3:0] slot_enable;
    logic [3:0] slot_done;
    logic       clear_overrun;
    logic [3:0] slot_start;
    logic [2:0] active_slot;
    logic [9:0] input_latched;
    logic       frame_busy;
    logic       frame_done;
    logic       overrun;
    logic [3:0] timeout_flags;

    // Responder: slot k returns done in its own start cycle unless masked off.
    logic [3:0] done_mask;
    logic [3:0] manual_done;
    assign slot_done = (slot_start & done_mask) | manual_done;

    int total;
    int bad;

    frame_tick_scheduler #(
        .NUM_SLOTS(4),
        .INPUT_W  (10),
        .TIMEOUT  (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .input_data   (input_data),
        .slot_enable  (slot_enable),
        .slot_done    (slot_done),
        .clear_overrun(clear_overrun),
        .slot_start   (slot_start),
        .active_slot  (active_slot),
        .input_latched(input_latched),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .timeout_flags(timeout_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a tick that is sampled by the next edge (edge n); returns after edge n.
    task automatic do_tick(input logic [9:0] data);
        frame_tick = 1'b1;
        input_data = data;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        total++;
        if ({slot_start, active_slot, input_latched, frame_busy, frame_done, overrun, timeout_flags} !== 24'd0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0",
                     {slot_start, active_slot, input_latched, frame_busy, frame_done, overrun, timeout_flags});
        end
    endtask

    // All slots enabled; input_data scrambled every cycle during the frame.
    task automatic test_full_frame();
        logic [3:0] exp_start;
        slot_enable = 4'b1111;
        done_mask   = 4'b1111;
        do_tick(10'h2A5);
        total++;
        if (frame_busy !== 1'b1 || slot_start !== 4'b0000) begin
            bad++;
            $display("FAIL full_n busy=%b start=%b want busy=1 start=0000", frame_busy, slot_start);
        end
        for (int k = 1; k <= 9; k++) begin
            input_data = 10'($urandom);
            step();
            case (k)
                1:       exp_start = 4'b0001;
                3:       exp_start = 4'b0010;
                5:       exp_start = 4'b0100;
                7:       exp_start = 4'b1000;
                default: exp_start = 4'b0000;
            endcase
            total++;
            if (slot_start !== exp_start) begin
                bad++;
                $display("FAIL full_start_n+%0d got=%b want=%b", k, slot_start, exp_start);
            end
            total++;
            if (frame_done !== (k == 9)) begin
                bad++;
                $display("FAIL full_done_n+%0d got=%b want=%b", k, frame_done, (k == 9));
            end
            total++;
            if (frame_busy !== (k <= 8)) begin
                bad++;
                $display("FAIL full_busy_n+%0d got=%b want=%b", k, frame_busy, (k <= 8));
            end
            total++;
            if (input_latched !== 10'h2A5) begin
                bad++;
                $display("FAIL full_latched_n+%0d got=%h want=2a5", k, input_latched);
            end
        end
        step();
        total++;
        if (frame_done !== 1'b0 || input_latched !== 10'h2A5) begin
            bad++;
            $display("FAIL full_after done=%b latched=%h want 0/2a5", frame_done, input_latched);
        end
    endtask

    // Slot 2 disabled: skipped in one cycle, never started.
    task automatic test_skip_disabled();
        logic [2:0] exp_act [0:7];
        logic [3:0] exp_start;
        exp_act[0] = 3'd0; exp_act[1] = 3'd0; exp_act[2] = 3'd1; exp_act[3] = 3'd1;
        exp_act[4] = 3'd2; exp_act[5] = 3'd3; exp_act[6] = 3'd3; exp_act[7] = 3'd4;
        slot_enable = 4'b1011;
        done_mask   = 4'b1111;
        do_tick(10'h155);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) step();
            case (k)
                1:       exp_start = 4'b0001;
                3:       exp_start = 4'b0010;
                6:       exp_start = 4'b1000;
                default: exp_start = 4'b0000;
            endcase
            total++;
            if (slot_start !== exp_start) begin
                bad++;
                $display("FAIL skip_start_n+%0d got=%b want=%b", k, slot_start, exp_start);
            end
            if (k <= 7) begin
                total++;
                if (active_slot !== exp_act[k]) begin
                    bad++;
                    $display("FAIL skip_active_n+%0d got=%0d want=%0d", k, active_slot, exp_act[k]);
                end
            end
            total++;
            if (frame_done !== (k == 8)) begin
                bad++;
                $display("FAIL skip_done_n+%0d got=%b want=%b", k, frame_done, (k == 8));
            end
        end
        slot_enable = 4'b1111;
    endtask

    task automatic test_overrun();
        int  cyc;
        logic seen;
        slot_enable = 4'b1111;
        done_mask   = 4'b1110;
        do_tick(10'h0F0);
        step();
        step();
        // Second tick sampled at edge n+3 while waiting on slot 0.
        do_tick(10'h3FF);
        total++;
        if (overrun !== 1'b1 || active_slot !== 3'd0 || frame_busy !== 1'b1 || input_latched !== 10'h0F0) begin
            bad++;
            $display("FAIL ovr_set ovr=%b act=%0d busy=%b lat=%h want 1/0/1/0f0",
                     overrun, active_slot, frame_busy, input_latched);
        end
        clear_overrun = 1'b1;
        step();
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_clear got=%b want=0", overrun);
        end
        frame_tick = 1'b1;
        step();
        frame_tick    = 1'b0;
        clear_overrun = 1'b0;
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_set_wins got=%b want=1", overrun);
        end
        // Release slot 0 and let the frame finish.
        manual_done = 4'b0001;
        step();
        manual_done = 4'b0000;
        done_mask   = 4'b1111;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 20) begin
            step();
            cyc++;
            if (frame_done) seen = 1'b1;
        end
        total++;
        if (!seen || input_latched !== 10'h0F0) begin
            bad++;
            $display("FAIL ovr_frame_end done_seen=%b lat=%h want 1/0f0", seen, input_latched);
        end
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        total++;
        if (overrun !== 1'b0 || frame_busy !== 1'b0) begin
            bad++;
            $display("FAIL ovr_final ovr=%b busy=%b want 0/0", overrun, frame_busy);
        end
    endtask

    task automatic test_watchdog();
`ifdef SCHED_WATCHDOG_EN
        slot_enable = 4'b1111;
        done_mask   = 4'b1101;
        do_tick(10'h011);
        // Slot 1 starts at n+3; WAIT edges n+4..n+18.
        for (int k = 1; k <= 17; k++) step();
        total++;
        if (timeout_flags !== 4'b0000 || active_slot !== 3'd1) begin
            bad++;
            $display("FAIL wd_before flags=%b act=%0d want 0000/1", timeout_flags, active_slot);
        end
        step();
        total++;
        if (timeout_flags !== 4'b0010 || active_slot !== 3'd2) begin
            bad++;
            $display("FAIL wd_fire flags=%b act=%0d want 0010/2", timeout_flags, active_slot);
        end
        step();
        total++;
        if (slot_start !== 4'b0100) begin
            bad++;
            $display("FAIL wd_slot2 got=%b want=0100", slot_start);
        end
        manual_done = 4'b0010;
        step();
        manual_done = 4'b0000;
        step();
        total++;
        if (slot_start !== 4'b1000) begin
            bad++;
            $display("FAIL wd_slot3 got=%b want=1000", slot_start);
        end
        step();
        step();
        total++;
        if (frame_done !== 1'b1 || timeout_flags !== 4'b0010) begin
            bad++;
            $display("FAIL wd_done done=%b flags=%b want 1/0010", frame_done, timeout_flags);
        end
        done_mask = 4'b1111;
`else
        total++;
        if (timeout_flags !== 4'b0000) begin
            bad++;
            $display("FAIL wd_tied got=%b want=0000", timeout_flags);
        end
`endif
    endtask

    task automatic test_async_reset();
        slot_enable = 4'b1111;
        done_mask   = 4'b1011;
        do_tick(10'h2C3);
        for (int k = 1; k <= 6; k++) step();
        total++;
        if (active_slot !== 3'd2 || frame_busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre act=%0d busy=%b want 2/1", active_slot, frame_busy);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({slot_start, active_slot, input_latched, frame_busy, frame_done, overrun, timeout_flags} !== 24'd0) begin
            bad++;
            $display("FAIL rst_async got=%h want=0",
                     {slot_start, active_slot, input_latched, frame_busy, frame_done, overrun, timeout_flags});
        end
        step();
        #2;
        reset     = 1'b1;
        done_mask = 4'b1111;
        step();
        do_tick(10'h001);
        step();
        total++;
        if (slot_start !== 4'b0001 || active_slot !== 3'd0 || input_latched !== 10'h001) begin
            bad++;
            $display("FAIL rst_restart start=%b act=%0d lat=%h want 0001/0/001",
                     slot_start, active_slot, input_latched);
        end
        for (int k = 2; k <= 9; k++) step();
        total++;
        if (frame_done !== 1'b1) begin
            bad++;
            $display("FAIL rst_restart_done got=%b want=1", frame_done);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        frame_tick    = 1'b0;
        input_data    = '0;
        slot_enable   = 4'b1111;
        done_mask     = 4'b1111;
        manual_done   = 4'b0000;
        clear_overrun = 1'b0;
        test_reset();
        test_full_frame();
        test_skip_disabled();
        test_overrun();
        test_watchdog();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_tick_scheduler.md
Name: frame_tick_scheduler

Overview:
- Per-frame sequencer for the game-entity update datapath (player FSM, enemy FSMs, collision/state controller).
- On each frame tick it latches the controller word once, then issues a one-cycle start strobe to each enabled entity slot in fixed ascending order. Each slot's done handshake is awaited before the next slot starts.
- Every entity therefore sees the same input snapshot and a deterministic update order, with no clk/trigger cross-timing between blocks.

Parameters:
- NUM_SLOTS, 4, number of sequenced entity slots (1..8).
- INPUT_W, 10, width of the controller input word.
- TIMEOUT, 15, watchdog limit in WAIT cycles (1..255); used only with SCHED_WATCHDOG_EN.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- frame_tick  in  1  single-cycle frame pulse, synchronous to clk.
- input_data  in  INPUT_W  raw controller word.
- slot_enable  in  NUM_SLOTS  per-slot enable, sampled when that slot is scanned.
- slot_done  in  NUM_SLOTS  per-slot completion handshake.
- clear_overrun  in  1  clears the overrun flag.
- slot_start  out  NUM_SLOTS  one-hot, one-cycle start strobe.
- active_slot  out  3  index of the slot currently scanned or awaited.
- input_latched  out  INPUT_W  controller snapshot for the current frame.
- frame_busy  out  1  high from tick acceptance until frame_done.
- frame_done  out  1  one-cycle pulse at end of the sequence.
- overrun  out  1  sticky: a tick arrived while busy.
- timeout_flags  out  NUM_SLOTS  sticky per-slot watchdog flags.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-frame):
  - state=IDLE, idx=0.
  - All outputs 0, including input_latched, overrun and timeout_flags.
  - Any in-flight slot is abandoned; no frame_done is issued.
- All outputs are registered.
- State IDLE:
  - On an edge sampling frame_tick=1: input_latched<=input_data, idx<=0, frame_busy<=1, go to SCAN.
- State SCAN (one edge per visit):
  - idx==NUM_SLOTS: frame_done<=1 for one cycle, frame_busy<=0, go to IDLE.
  - slot_enable[idx]=0: idx<=idx+1, stay in SCAN (a disabled slot costs one cycle).
  - slot_enable[idx]=1: slot_start<=one-hot(idx) for exactly one cycle, watchdog counter cleared, go to WAIT.
- State WAIT:
  - An edge sampling slot_done[idx]=1 sets idx<=idx+1 and returns to SCAN.
  - slot_done may already be high in the start-strobe cycle; it is accepted.
  - slot_done bits for any other slot are ignored in every state.
- active_slot = idx, truncated to 3 bits.
- Latency, all slots enabled, each done returned in its start cycle:
  - slot k start is high in the cycle after edge n+1+2k (n = tick edge).
  - frame_done is high after edge n+2*NUM_SLOTS+1.
- Overrun:
  - frame_tick=1 while frame_busy=1 (including the frame_done cycle, since busy drops with it): tick dropped, overrun<=1.
  - clear_overrun=1 clears overrun; if set and clear coincide, set wins.
- input_latched holds its value until the next accepted tick; input changes mid-frame are not visible.
- slot_enable changes only affect slots not yet scanned.

Optional Feature:
- Macro: SCHED_WATCHDOG_EN.
- Defined:
  - An 8-bit counter runs in WAIT.
  - If slot_done[idx] is not sampled high within TIMEOUT consecutive WAIT edges, then at the TIMEOUT-th edge: timeout_flags[idx]<=1 (sticky until reset), idx<=idx+1, go to SCAN.
  - A late done from that slot is ignored.
- Undefined:
  - WAIT waits indefinitely.
  - timeout_flags is tied to 0 and no counter logic is present.

Test Plan:
- All 4 slots enabled, slot_done[k] pulsed coincident with slot_start[k], input_data=10'h2A5 at tick -> starts 0001,0010,0100,1000 after edges n+1,n+3,n+5,n+7; frame_done after edge n+9; input_latched=10'h2A5; frame_busy high after edges n..n+8.
- slot_enable=4'b1011, same done timing -> slot 2 never started; frame_done after edge n+8; active_slot steps 0,0,1,1,2,3,3,4.
- Second frame_tick 3 cycles after the first, slot 0 done withheld -> overrun=1 and frame unaffected; clear_overrun pulse -> overrun=0; clear and new overrun in the same cycle -> overrun stays 1.
- SCHED_WATCHDOG_EN with TIMEOUT=15, slot 1 never signals done -> timeout_flags=4'b0010 at the 15th WAIT edge; slots 2 and 3 then sequence normally; frame_done still issued.
- reset=0 asserted while in WAIT on slot 2 -> all outputs 0 immediately without a clock edge; after release the next tick restarts from slot 0.
- input_data changed every cycle during a frame -> input_latched constant until the next accepted tick.
